vadd_chunk_scheduler: RTL
=========================

Name: vadd_chunk_scheduler

Overview:
- Kernel-level sequencer in front of the vadd datapath (read master -> adder -> write master).
- Accepts one host job (base address, total byte count, constant) over ap_ctrl_hs-style handshakes and splits it into chunks of at most C_CHUNK_BYTES.
- Issues each chunk to the datapath as a start/done transaction.
- Reports ap_ready/ap_done/ap_idle back to the host control block.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, address width of offsets.
- C_XFER_SIZE_WIDTH, 32, width of byte counts.
- C_ADDER_BIT_WIDTH, 32, width of the adder constant.
- C_CHUNK_BYTES, 4096, maximum bytes per datapath launch; must be a nonzero multiple of 64.

Ports:
- aclk  in  1  kernel clock.
- areset  in  1  synchronous reset, active-high.
- ap_start  in  1  host start request; level, held until ap_ready.
- ap_ready  out  1  one-cycle pulse when job config is latched.
- ap_done  out  1  one-cycle pulse when the whole job is complete.
- ap_idle  out  1  high only while in IDLE.
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  job base address.
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  job total bytes.
- ctrl_constant  in  C_ADDER_BIT_WIDTH  adder constant.
- dp_start  out  1  one-cycle datapath launch pulse.
- dp_done  in  1  one-cycle datapath completion pulse (write side done).
- dp_addr_offset  out  C_M_AXI_ADDR_WIDTH  chunk address; stable from dp_start until dp_done.
- dp_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  chunk bytes; stable from dp_start until dp_done.
- dp_constant  out  C_ADDER_BIT_WIDTH  latched constant; stable for the whole job.

Behaviour:
- Single clock aclk; areset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state = IDLE, ap_idle = 1.
  - ap_ready, ap_done, dp_start = 0.
  - dp_addr_offset, dp_xfer_size_in_bytes, dp_constant = 0.
  - Internal remaining count and current address = 0.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - When ap_start = 1 in cycle N: latch addr, size and constant; remaining = size.
  - If size == 0, go to DONE. Otherwise go to LAUNCH.
  - ap_ready = 1 in cycle N+1 only. ap_idle = 0 from N+1.
- LAUNCH (one cycle):
  - dp_start = 1.
  - chunk = min(remaining, C_CHUNK_BYTES), driven on dp_xfer_size_in_bytes; dp_addr_offset = current address.
  - Go to WAIT.
- WAIT:
  - On dp_done = 1: remaining -= chunk; address += chunk, modulo 2^C_M_AXI_ADDR_WIDTH (wraps silently).
  - If the new remaining == 0, go to DONE; otherwise go to LAUNCH.
  - So the next dp_start, or ap_done, appears one cycle after dp_done.
- DONE (one cycle):
  - ap_done = 1. Go to IDLE; ap_idle = 1 from the following cycle.
- Job latency:
  - First dp_start is 1 cycle after ap_start is sampled.
  - Inter-chunk gap is 1 idle cycle (dp_done -> LAUNCH -> dp_start).
- Last chunk: may be any byte count 1..C_CHUNK_BYTES, including non-multiples of 64; passed through unchanged.
- Boundary conditions:
  - ap_start while not in IDLE is ignored. A held ap_start after DONE starts a new job on the first IDLE cycle.
  - dp_done outside WAIT is ignored; no count change.
  - areset asserted mid-job returns to IDLE on the next edge with reset values. An in-flight datapath transfer is abandoned; its later dp_done is ignored.
  - Size of exactly k*C_CHUNK_BYTES yields k launches with no zero-length chunk.

Optional Feature:
- Macro: VADD_CHUNK_SCHED_PERF_CNT_EN.
- When defined:
  - Adds output perf_cycles (64 bits).
  - Cleared on ap_ready; increments every cycle while state != IDLE; holds after DONE until the next job; reset to 0.
  - Adds output perf_chunks (32 bits), counting dp_start pulses in the current job under the same clear/hold rules.
- When not defined: neither port nor its logic exists, and behaviour is otherwise identical.

Test Plan:
- Zero-length job: ctrl_xfer_size_in_bytes = 0, ap_start = 1 -> ap_ready and no dp_start; ap_done one cycle after ap_ready; ap_idle back to 1 next cycle.
- Exact multiple: addr 0x1000, size 8192 -> two dp_start pulses, (0x1000, 4096) then (0x2000, 4096); ap_done 1 cycle after the second dp_done.
- Partial tail: addr 0x1000, size 10000 -> chunks (0x1000, 4096), (0x2000, 4096), (0x3000, 1808); then ap_done.
- Busy-start and stray done: ap_start toggled during WAIT and dp_done pulsed during LAUNCH -> no extra launches; remaining unchanged; only 3 chunks for size 10000.
- Mid-job reset: areset during WAIT of chunk 2 -> next cycle all outputs at reset values, ap_idle = 1; a subsequent dp_done is ignored; a new job of size 64 completes with a single (base, 64) chunk.
- Perf counters with VADD_CHUNK_SCHED_PERF_CNT_EN defined, size 10000 and dp_done returned 10 cycles after each dp_start -> perf_chunks = 3 and perf_cycles = 34 at ap_done, both holding afterwards.

Source files
------------

// File: rtl/vadd_chunk_scheduler_if.sv
// rtl/vadd_chunk_scheduler_if.sv - host control and datapath launch signals of vadd_chunk_scheduler
// master = scheduler side, slave = host control block plus datapath.
interface vadd_chunk_scheduler_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32
);
  logic                          ap_start;
  logic                          ap_ready;
  logic                          ap_done;
  logic                          ap_idle;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes;
  logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_constant;
  logic                          dp_start;
  logic                          dp_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0] dp_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  dp_xfer_size_in_bytes;
  logic [C_ADDER_BIT_WIDTH-1:0]  dp_constant;

  modport master (
    input  ap_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, ctrl_constant, dp_done,
    output ap_ready, ap_done, ap_idle, dp_start, dp_addr_offset, dp_xfer_size_in_bytes, dp_constant
  );

  modport slave (
    output ap_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, ctrl_constant, dp_done,
    input  ap_ready, ap_done, ap_idle, dp_start, dp_addr_offset, dp_xfer_size_in_bytes, dp_constant
  );
endinterface

// File: rtl/vadd_chunk_scheduler.sv
// rtl/vadd_chunk_scheduler.sv - splits one host vadd job into datapath chunks of at most C_CHUNK_BYTES
// Optional perf_cycles/perf_chunks outputs are built when VADD_CHUNK_SCHED_PERF_CNT_EN is defined.
module vadd_chunk_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_CHUNK_BYTES      = 4096
) (
  input  logic                         aclk,
  input  logic                         areset,
  vadd_chunk_scheduler_if.master       bus
`ifdef VADD_CHUNK_SCHED_PERF_CNT_EN
  ,
  output logic [63:0]                  perf_cycles,
  output logic [31:0]                  perf_chunks
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [C_XFER_SIZE_WIDTH-1:0] CHUNK = C_XFER_SIZE_WIDTH'(C_CHUNK_BYTES);

  state_t                         state;
  logic [C_XFER_SIZE_WIDTH-1:0]   remaining;
  logic [C_XFER_SIZE_WIDTH-1:0]   rem_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0]  addr_next;

  function automatic logic [C_XFER_SIZE_WIDTH-1:0] clip(input logic [C_XFER_SIZE_WIDTH-1:0] n);
    return (n > CHUNK) ? CHUNK : n;
  endfunction

  // dp_addr_offset doubles as the running address; it wraps modulo 2^C_M_AXI_ADDR_WIDTH.
  assign rem_next  = remaining - bus.dp_xfer_size_in_bytes;
  assign addr_next = bus.dp_addr_offset + C_M_AXI_ADDR_WIDTH'(bus.dp_xfer_size_in_bytes);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state                     <= ST_IDLE;
      remaining                 <= '0;
      bus.ap_ready              <= 1'b0;
      bus.ap_done               <= 1'b0;
      bus.ap_idle               <= 1'b1;
      bus.dp_start              <= 1'b0;
      bus.dp_addr_offset        <= '0;
      bus.dp_xfer_size_in_bytes <= '0;
      bus.dp_constant           <= '0;
`ifdef VADD_CHUNK_SCHED_PERF_CNT_EN
      perf_cycles               <= '0;
      perf_chunks               <= '0;
`endif
    end else begin
      bus.ap_ready <= 1'b0;
      bus.ap_done  <= 1'b0;
      bus.dp_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.ap_start) begin
            bus.ap_ready              <= 1'b1;
            bus.ap_idle               <= 1'b0;
            bus.dp_addr_offset        <= bus.ctrl_addr_offset;
            bus.dp_constant           <= C_ADDER_BIT_WIDTH'(bus.ctrl_constant);
            bus.dp_xfer_size_in_bytes <= clip(bus.ctrl_xfer_size_in_bytes);
            remaining                 <= bus.ctrl_xfer_size_in_bytes;
`ifdef VADD_CHUNK_SCHED_PERF_CNT_EN
            perf_cycles               <= 64'd1;
            perf_chunks               <= (bus.ctrl_xfer_size_in_bytes == '0) ? 32'd0 : 32'd1;
`endif
            if (bus.ctrl_xfer_size_in_bytes == '0) begin
              state <= ST_DONE;
            end else begin
              state        <= ST_LAUNCH;
              bus.dp_start <= 1'b1;
            end
          end
        end

        ST_LAUNCH: begin
          state <= ST_WAIT;
`ifdef VADD_CHUNK_SCHED_PERF_CNT_EN
          perf_cycles <= perf_cycles + 64'd1;
`endif
        end

        ST_WAIT: begin
`ifdef VADD_CHUNK_SCHED_PERF_CNT_EN
          perf_cycles <= perf_cycles + 64'd1;
`endif
          if (bus.dp_done) begin
            remaining          <= rem_next;
            bus.dp_addr_offset <= addr_next;
            if (rem_next == '0) begin
              state       <= ST_DONE;
              bus.ap_done <= 1'b1;
            end else begin
              state                     <= ST_LAUNCH;
              bus.dp_start              <= 1'b1;
              bus.dp_xfer_size_in_bytes <= clip(rem_next);
`ifdef VADD_CHUNK_SCHED_PERF_CNT_EN
              perf_chunks               <= perf_chunks + 32'd1;
`endif
            end
          end
        end

        ST_DONE: begin
          // A zero-length job enters here together with ap_ready; it stays one
          // extra cycle so ap_done never coincides with ap_ready.
          if (bus.ap_done) begin
            state       <= ST_IDLE;
            bus.ap_idle <= 1'b1;
          end else begin
            bus.ap_done <= 1'b1;
`ifdef VADD_CHUNK_SCHED_PERF_CNT_EN
            perf_cycles <= perf_cycles + 64'd1;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
